// File: rtl/fpga_cfg_pkg.sv
// Shared types and sizing helpers for the configuration-chain loader.
// Sizes are derived from the chain length and the memory word width.
package fpga_cfg_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_CHAIN_LEN = 7778;

    function automatic int num_words(input int chain_len, input int word_w);
        return (chain_len + word_w - 1) / word_w;
    endfunction

    // Bits actually used from the final word of the bitstream.
    function automatic int last_bits(input int chain_len, input int word_w);
        return ((chain_len % word_w) == 0) ? word_w : (chain_len % word_w);
    endfunction

endpackage

// File: rtl/fpga_config_loader_prefetch.sv
// Word fetcher: drives the memory read handshake and keeps the word being
// shifted plus one prefetched word, so shifting continues across word edges.
module cfg_word_prefetch #(
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int NUM_WORDS = 244
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_restart,
    input  logic              i_consume,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_valid,
    input  logic [WORD_W-1:0] i_rd_data,
    output logic [WORD_W-1:0] o_word,
    output logic              o_word_avail
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_WORDS);

    logic              r_req;
    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_cur;
    logic              r_cur_valid;
    logic [WORD_W-1:0] r_nxt;
    logic              r_nxt_valid;

    logic w_fill;
    logic w_cur_free;

    assign w_fill     = r_req && i_rd_valid;
    assign w_cur_free = !r_cur_valid || i_consume;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_req       <= 1'b0;
            r_cnt       <= '0;
            r_cur       <= '0;
            r_cur_valid <= 1'b0;
            r_nxt       <= '0;
            r_nxt_valid <= 1'b0;
        end else if (i_restart) begin
            r_req       <= 1'b0;
            r_cnt       <= '0;
            r_cur_valid <= 1'b0;
            r_nxt_valid <= 1'b0;
        end else begin
            // Only one request in flight, and only when a slot is free for its data.
            if (w_fill) begin
                r_req <= 1'b0;
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (i_enable && !r_req && !r_nxt_valid && (r_cnt < LAST_CNT)) begin
                r_req <= 1'b1;
            end

            if (w_cur_free) begin
                if (r_nxt_valid) begin
                    r_cur       <= r_nxt;
                    r_cur_valid <= 1'b1;
                    r_nxt_valid <= w_fill;
                    if (w_fill) begin
                        r_nxt <= i_rd_data;
                    end
                end else begin
                    r_cur_valid <= w_fill;
                    if (w_fill) begin
                        r_cur <= i_rd_data;
                    end
                end
            end else if (w_fill) begin
                r_nxt       <= i_rd_data;
                r_nxt_valid <= 1'b1;
            end
        end
    end

    assign o_rd_req     = r_req;
    assign o_rd_addr    = r_cnt[ADDR_W-1:0];
    assign o_word       = r_cur;
    assign o_word_avail = r_cur_valid;

endmodule

// File: rtl/fpga_config_loader.sv
// Configuration chain loader: shifts the memory bitstream LSB-first into the
// chain and optionally shifts it again while checking the chain tail.
module fpga_config_loader
    import fpga_cfg_pkg::*;
#(
    parameter int CHAIN_LEN = DEFAULT_CHAIN_LEN,
    parameter int WORD_W    = 32,
    parameter int ADDR_W    = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_verify,
    output logic              o_rd_req,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic              i_rd_valid,
    input  logic [WORD_W-1:0] i_rd_data,
    output logic              o_config_en,
    output logic              o_config_in,
    input  logic              i_config_out,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_verify_err,
    output logic [15:0]       o_err_count
);

    localparam int NUM_WORDS = num_words(CHAIN_LEN, WORD_W);
    localparam int BIT_W     = $clog2(CHAIN_LEN + 1);
    localparam int WBIT_W    = $clog2(WORD_W);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(CHAIN_LEN - 1);
    localparam logic [WBIT_W-1:0] LAST_WBIT = WBIT_W'(WORD_W - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [BIT_W-1:0]  r_bit;
    logic [WBIT_W-1:0] r_wbit;
    logic              r_pass;
    logic              r_verify;
    logic              r_verify_err;
    logic [15:0]       r_err_count;

    logic [WORD_W-1:0] w_word;
    logic              w_avail;
    logic              w_en;
    logic              w_bit_exp;
    logic              w_last_bit;
    logic              w_consume;
    logic              w_restart;
    logic              w_start_ok;
    logic              w_mismatch;

    cfg_word_prefetch #(
        .WORD_W    (WORD_W),
        .ADDR_W    (ADDR_W),
        .NUM_WORDS (NUM_WORDS)
    ) u_prefetch (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_enable     (o_busy),
        .i_restart    (w_restart),
        .i_consume    (w_consume),
        .o_rd_req     (o_rd_req),
        .o_rd_addr    (o_rd_addr),
        .i_rd_valid   (i_rd_valid),
        .i_rd_data    (i_rd_data),
        .o_word       (w_word),
        .o_word_avail (w_avail)
    );

    assign w_en       = (r_state == SHIFT) && w_avail;
    assign w_bit_exp  = w_word[r_wbit];
    assign w_last_bit = (r_bit == LAST_BIT);
    // The final word may be partial, so the chain end also retires it.
    assign w_consume  = w_en && ((r_wbit == LAST_WBIT) || w_last_bit);
    assign w_mismatch = w_en && r_pass && (i_config_out != w_bit_exp);

    always_comb begin
        w_state_nxt = r_state;
        w_start_ok  = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_start_ok  = 1'b1;
                    w_restart   = 1'b1;
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (w_en && w_last_bit) begin
                    if (r_verify && !r_pass) begin
                        w_restart = 1'b1;
                    end else begin
                        w_state_nxt = DONE;
                    end
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_bit        <= '0;
            r_wbit       <= '0;
            r_pass       <= 1'b0;
            r_verify     <= 1'b0;
            r_verify_err <= 1'b0;
            r_err_count  <= '0;
        end else if (w_start_ok) begin
            r_bit        <= '0;
            r_wbit       <= '0;
            r_pass       <= 1'b0;
            r_verify     <= i_verify;
            r_verify_err <= 1'b0;
            r_err_count  <= '0;
        end else if (w_en) begin
            if (w_last_bit) begin
                r_bit  <= '0;
                r_wbit <= '0;
                r_pass <= r_verify;
            end else begin
                r_bit  <= r_bit + BIT_W'(1);
                r_wbit <= (r_wbit == LAST_WBIT) ? '0 : r_wbit + WBIT_W'(1);
            end
            if (w_mismatch) begin
                r_verify_err <= 1'b1;
                if (r_err_count != 16'hFFFF) begin
                    r_err_count <= r_err_count + 16'd1;
                end
            end
        end
    end

    assign o_config_en  = w_en;
    assign o_config_in  = w_en && w_bit_exp;
    assign o_busy       = (r_state == SHIFT);
    assign o_done       = (r_state == DONE);
    assign o_verify_err = r_verify_err;
    assign o_err_count  = r_err_count;

endmodule
